// File: rtl/btn_debounce_pulse_pkg.sv
// Shared constants for the calculator button front end.
//   - Pulse-FSM state encodings (2-bit, kept as plain constants so older
//     tools and netlist readers see fixed codes).
//   - Default SAMPLE_DIV / DB_DEPTH for simulation and for board builds.
//     BOARD_SAMPLE_DIV gives a ~1 ms sample tick from a 50 MHz clock.
package btn_debounce_pulse_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_PULSE = 2'b01;
  localparam logic [1:0] ST_HOLD  = 2'b10;

  localparam int SIM_SAMPLE_DIV   = 4;
  localparam int SIM_DB_DEPTH     = 4;
  localparam int BOARD_SAMPLE_DIV = 50000;
  localparam int BOARD_DB_DEPTH   = 4;

endpackage

// File: rtl/btn_debounce_pulse_sync.sv
// sync_2ff: generic two-flop synchroniser for asynchronous pad inputs.
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-high reset, clears both stages
//   d    - asynchronous input
//   q    - synchronised output (two clk cycles of latency)
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/btn_debounce_pulse.sv
// btn_debounce_pulse: turns one raw push-button into a debounced level and
// a single-cycle press strobe for the calculator control FSM.
// Ports:
//   clk       - system clock
//   rst       - asynchronous active-high reset
//   btn_raw   - raw button (asynchronous to clk), 1 = pressed
//   btn_level - debounced button level
//   pulse     - one-cycle strobe per qualified press (Moore output)
// Parameters:
//   SAMPLE_DIV - clock cycles per sample tick (1..65536)
//   DB_DEPTH   - consecutive equal samples to change btn_level (2..16)
//
// Pulse FSM:
//   state    | meaning
//   ST_IDLE  | button released, waiting for debounced level to rise
//   ST_PULSE | level just rose, pulse asserted for this one cycle
//   ST_HOLD  | button held, waiting for debounced level to fall
module btn_debounce_pulse
  import btn_debounce_pulse_pkg::*;
#(
  parameter int SAMPLE_DIV = SIM_SAMPLE_DIV,
  parameter int DB_DEPTH   = SIM_DB_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic pulse
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  logic                btn_sync;
  logic                tick;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [DB_DEPTH-1:0] smp_q, smp_d;
  logic                level_q, level_d;
  logic [1:0]          state_q, state_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (btn_sync)
  );

  // With SAMPLE_DIV == 1 the counter is stuck at 0 and tick is always true.
  assign tick = (div_cnt_q == DIV_LAST);

  always_comb begin
    div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    smp_d     = tick ? {smp_q[DB_DEPTH-2:0], btn_sync} : smp_q;

    // Level only moves on a unanimous sample window; mixed windows hold.
    level_d = level_q;
    if (&smp_q) begin
      level_d = 1'b1;
    end else if (~|smp_q) begin
      level_d = 1'b0;
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:  state_d = level_q ? ST_PULSE : ST_IDLE;
      ST_PULSE: state_d = ST_HOLD;
      ST_HOLD:  state_d = level_q ? ST_HOLD : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      smp_q     <= '0;
      level_q   <= 1'b0;
      state_q   <= ST_IDLE;
    end else begin
      div_cnt_q <= div_cnt_d;
      smp_q     <= smp_d;
      level_q   <= level_d;
      state_q   <= state_d;
    end
  end

  assign btn_level = level_q;
  assign pulse     = (state_q == ST_PULSE);

endmodule

// File: tb/tb_btn_debounce_pulse.sv
module tb_btn_debounce_pulse;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_raw = 1'b0;
  logic btn_level;
  logic pulse;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-run statistics gathered by run()
  int npulse, first_pulse, first_rise, nrise, nfall, wide, orphan;

  always #5 clk = ~clk;

  btn_debounce_pulse #(.SAMPLE_DIV(4), .DB_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .pulse     (pulse)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    n_tests++;
    assert (obs >= lo && obs <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Advance n cycles with btn_raw held at v. Sample index 0 is the first
  // edge after the call (the edge where the new btn_raw is first seen).
  task automatic run(input int n, input logic v);
    logic prev_p, prev_l;
    btn_raw = v;
    npulse = 0; first_pulse = -1; first_rise = -1;
    nrise = 0; nfall = 0; wide = 0; orphan = 0;
    prev_p = pulse;
    prev_l = btn_level;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (pulse) begin
        npulse++;
        if (first_pulse < 0) first_pulse = i;
        if (prev_p) wide++;
        if (!btn_level) orphan++;
      end
      if (btn_level && !prev_l) begin
        nrise++;
        if (first_rise < 0) first_rise = i;
      end
      if (!btn_level && prev_l) nfall++;
      prev_p = pulse;
      prev_l = btn_level;
    end
  endtask

  initial begin
    int found;

    // Reset check: rst high 3 cycles with button pressed
    btn_raw = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_level", btn_level, 0);
      chk("rst_pulse", pulse, 0);
    end
    rst = 1'b0;
    run(30, 1'b1);
    chk("rst_rel_npulse", npulse, 1);
    chk_rng("rst_rel_latency", first_pulse, 16, 19);
    chk("rst_rel_level", btn_level, 1);

    // Release fully
    run(40, 1'b0);
    chk("rel0_npulse", npulse, 0);
    chk("rel0_level", btn_level, 0);
    chk("rel0_nfall", nfall, 1);

    // Clean press held 40 cycles
    run(40, 1'b1);
    chk("clean_npulse", npulse, 1);
    chk_rng("clean_latency", first_pulse, 16, 19);
    chk("clean_rise_before_pulse", first_rise, first_pulse - 1);
    chk("clean_wide", wide, 0);
    chk("clean_orphan", orphan, 0);
    chk("clean_level", btn_level, 1);
    run(40, 1'b0);
    chk("clean_rel_npulse", npulse, 0);
    chk("clean_rel_level", btn_level, 0);

    // Press bounce: 1,0,1,0 every 3 cycles for 24 cycles, then settle high
    found = 0;
    for (int s = 0; s < 8; s++) begin
      run(3, (s % 2 == 0) ? 1'b1 : 1'b0);
      found += npulse + nrise;
    end
    chk("bounce_quiet", found, 0);
    run(40, 1'b1);
    chk("bounce_npulse", npulse, 1);
    chk("bounce_wide", wide, 0);
    chk("bounce_level", btn_level, 1);

    // Release bounce: three 5-cycle bounces, then settle low
    found = 0;
    for (int s = 0; s < 6; s++) begin
      run(5, (s % 2 == 0) ? 1'b0 : 1'b1);
      found += npulse + nfall;
    end
    chk("relbounce_quiet", found, 0);
    chk("relbounce_level_held", btn_level, 1);
    run(40, 1'b0);
    chk("relbounce_nfall", nfall, 1);
    chk("relbounce_npulse", npulse, 0);
    chk("relbounce_level", btn_level, 0);

    // Two presses
    found = 0;
    run(40, 1'b1); found += npulse;
    run(40, 1'b0); found += npulse;
    run(40, 1'b1); found += npulse;
    chk("two_press_npulse", found, 2);
    run(40, 1'b0);
    chk("two_press_rel_level", btn_level, 0);

    // Reset mid-operation, asserted in the pulse cycle
    btn_raw = 1'b1;
    found = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (pulse) begin
        found = 1;
        break;
      end
    end
    chk("mid_pulse_seen", found, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_pulse", pulse, 0);
    chk("mid_rst_level", btn_level, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_rst_hold_pulse", pulse, 0);
    rst = 1'b0;
    run(30, 1'b1);
    chk("mid_rel_npulse", npulse, 1);
    chk_rng("mid_rel_latency", first_pulse, 16, 19);
    chk("mid_rel_wide", wide, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
